// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard sequencer: FSM state encoding
// and the bundle of pipeline-register controls produced by the priority decode.
package hazard_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int PERF_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  typedef struct packed {
    logic stall_ifid;
    logic flush_ifid;
    logic stall_idexe;
    logic flush_idexe;
    logic stall_exemem;
    logic flush_exemem;
    logic stall_memwb;
    logic flush_memwb;
    logic pc_write_en;
  } ctl_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline <-> hazard unit signal bundle. The hazard unit takes the slave side;
// the pipeline (or a bench) takes the master side.
interface hazard_sequencer_if;
  import hazard_pkg::*;

  logic [REG_IDX_W-1:0]  ID_RS;
  logic [REG_IDX_W-1:0]  ID_RT;
  logic                  ID_USES_RT;
  logic                  EXE_MEMREAD;
  logic [REG_IDX_W-1:0]  EXE_RD;
  logic                  EXE_BRANCH_TAKEN;
  logic                  DMEM_REQ;
  logic                  DMEM_READY;

  logic                  STALL_IFID;
  logic                  FLUSH_IFID;
  logic                  STALL_IDEXE;
  logic                  FLUSH_IDEXE;
  logic                  STALL_EXEMEM;
  logic                  FLUSH_EXEMEM;
  logic                  STALL_MEMWB;
  logic                  FLUSH_MEMWB;
  logic                  PC_WRITE_EN;
  logic                  MEM_TIMEOUT;
  logic [PERF_CNT_W-1:0] STALL_CYCLES;

  modport master (
    output ID_RS, ID_RT, ID_USES_RT, EXE_MEMREAD, EXE_RD, EXE_BRANCH_TAKEN,
           DMEM_REQ, DMEM_READY,
    input  STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM,
           FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB, PC_WRITE_EN, MEM_TIMEOUT,
           STALL_CYCLES
  );

  modport slave (
    input  ID_RS, ID_RT, ID_USES_RT, EXE_MEMREAD, EXE_RD, EXE_BRANCH_TAKEN,
           DMEM_REQ, DMEM_READY,
    output STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM,
           FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB, PC_WRITE_EN, MEM_TIMEOUT,
           STALL_CYCLES
  );

endinterface

// File: rtl/hazard_loaduse_detect.sv
// Load-use compare: a load in EXE whose destination is read by the ID instruction.
// Register $0 is hardwired to zero, so a load targeting it never creates a hazard.
module hazard_loaduse_detect
  import hazard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 exe_memread,
  input  logic [REG_IDX_W-1:0] exe_rd,
  output logic                 load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = (exe_rd == id_rs);
  assign rt_hit   = id_uses_rt && (exe_rd == id_rt);
  assign load_use = exe_memread && (exe_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use bubbles, branch redirects, data-memory waits
// with a sticky timeout. Optional stall-cycle counter enabled by HAZARD_PERF_EN.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT_CYCLES = 255
) (
  input  logic               CLOCK,
  input  logic               RESET,
  hazard_sequencer_if.slave  bus
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  ctl_t              ctl;

  hazard_loaduse_detect u_loaduse (
    .id_rs       (bus.ID_RS),
    .id_rt       (bus.ID_RT),
    .id_uses_rt  (bus.ID_USES_RT),
    .exe_memread (bus.EXE_MEMREAD),
    .exe_rd      (bus.EXE_RD),
    .load_use    (load_use)
  );

  assign mem_stall = ((state == RUN)      && bus.DMEM_REQ && !bus.DMEM_READY) ||
                     ((state == MEM_WAIT) && !bus.DMEM_READY);

  always_ff @(posedge CLOCK) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (!RESET) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment up front keeps every path assigned, so no latch is inferred.
    state_next = state;
    case (state)
      RUN: begin
        // A one-cycle bound expires on the very first miss.
        if (mem_stall) state_next = (MEM_TIMEOUT_CYCLES == 1) ? ERROR : MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.DMEM_READY)           state_next = RUN;
        else if (wait_cnt >= WAIT_LAST) state_next = ERROR;
      end
      ERROR:   state_next = ERROR;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET)         wait_cnt <= '0;
    else if (mem_stall) wait_cnt <= wait_cnt + 1'b1;
    else                wait_cnt <= '0;
  end

  always_comb begin
    ctl = '0;
    if (!RESET) begin
      ctl = '0;
    end else if (state == ERROR) begin
      ctl.stall_ifid   = 1'b1;
      ctl.stall_idexe  = 1'b1;
      ctl.stall_exemem = 1'b1;
      ctl.stall_memwb  = 1'b1;
    end else if (mem_stall) begin
      // EXE is held, so a masked redirect or load-use is seen again on release.
      ctl.stall_ifid   = 1'b1;
      ctl.stall_idexe  = 1'b1;
      ctl.stall_exemem = 1'b1;
      ctl.flush_memwb  = 1'b1;
    end else if (bus.EXE_BRANCH_TAKEN) begin
      ctl.flush_ifid   = 1'b1;
      ctl.flush_idexe  = 1'b1;
      ctl.pc_write_en  = 1'b1;
    end else if (load_use) begin
      ctl.stall_ifid   = 1'b1;
      ctl.flush_idexe  = 1'b1;
    end else begin
      ctl.pc_write_en  = 1'b1;
    end
  end

  assign bus.STALL_IFID   = ctl.stall_ifid;
  assign bus.FLUSH_IFID   = ctl.flush_ifid;
  assign bus.STALL_IDEXE  = ctl.stall_idexe;
  assign bus.FLUSH_IDEXE  = ctl.flush_idexe;
  assign bus.STALL_EXEMEM = ctl.stall_exemem;
  assign bus.FLUSH_EXEMEM = ctl.flush_exemem;
  assign bus.STALL_MEMWB  = ctl.stall_memwb;
  assign bus.FLUSH_MEMWB  = ctl.flush_memwb;
  assign bus.PC_WRITE_EN  = ctl.pc_write_en;
  assign bus.MEM_TIMEOUT  = (state == ERROR);

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cycles;

  always_ff @(posedge CLOCK) begin
    if (!RESET)                                     stall_cycles <= '0;
    else if (!ctl.pc_write_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end

  assign bus.STALL_CYCLES = stall_cycles;
`else
  assign bus.STALL_CYCLES = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer (MEM_TIMEOUT_CYCLES=4): directed vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_hazard_sequencer;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;

  hazard_sequencer_if hif ();

  hazard_sequencer #(.MEM_TIMEOUT_CYCLES(4)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (hif)
  );

  always #5 CLOCK = ~CLOCK;

  // Bit order: s_ifid f_ifid s_idexe f_idexe s_exemem f_exemem s_memwb f_memwb pc_we tmo
  typedef logic [9:0] exp_ctl_t;

  localparam exp_ctl_t C_RST     = 10'b0000000000;
  localparam exp_ctl_t C_RST_TMO = 10'b0000000001;
  localparam exp_ctl_t C_IDLE    = 10'b0000000010;
  localparam exp_ctl_t C_LU      = 10'b1001000000;
  localparam exp_ctl_t C_BR      = 10'b0101000010;
  localparam exp_ctl_t C_MS      = 10'b1010100100;
  localparam exp_ctl_t C_ERR     = 10'b1010101001;

`ifdef HAZARD_PERF_EN
  localparam logic [15:0] PERF_AFTER_LU_MW = 16'd4;
`else
  localparam logic [15:0] PERF_AFTER_LU_MW = 16'd0;
`endif

  typedef struct {
    exp_ctl_t    ctl;
    bit          chk_perf;
    logic [15:0] perf;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic drive(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                       input bit uses_rt, input bit memread, input logic [4:0] rd,
                       input bit br, input bit req, input bit rdy,
                       input exp_ctl_t c, input string nm,
                       input bit chk_perf, input logic [15:0] perf);
    exp_t e;
    @(posedge CLOCK);
    #1;
    RESET                = rst;
    hif.ID_RS            = rs;
    hif.ID_RT            = rt;
    hif.ID_USES_RT       = uses_rt;
    hif.EXE_MEMREAD      = memread;
    hif.EXE_RD           = rd;
    hif.EXE_BRANCH_TAKEN = br;
    hif.DMEM_REQ         = req;
    hif.DMEM_READY       = rdy;
    e.ctl      = c;
    e.chk_perf = chk_perf;
    e.perf     = perf;
    e.name     = nm;
    exp_q.push_back(e);
  endtask

  // Shorthands for the common vector shapes.
  task automatic idle(input exp_ctl_t c, input string nm);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, c, nm, 0, 16'd0);
  endtask

  task automatic mem(input bit req, input bit rdy, input bit br, input exp_ctl_t c, input string nm);
    drive(1, 0, 0, 0, 0, 0, br, req, rdy, c, nm, 0, 16'd0);
  endtask

  initial begin : monitor
    exp_t     e;
    exp_ctl_t got;
    forever begin
      @(negedge CLOCK);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {hif.STALL_IFID, hif.FLUSH_IFID, hif.STALL_IDEXE, hif.FLUSH_IDEXE,
               hif.STALL_EXEMEM, hif.FLUSH_EXEMEM, hif.STALL_MEMWB, hif.FLUSH_MEMWB,
               hif.PC_WRITE_EN, hif.MEM_TIMEOUT};
        n_cmp++;
        if (got !== e.ctl) begin
          n_bad++;
          $display("FAIL %s: ctl got %b expected %b", e.name, got, e.ctl);
        end
        if (e.chk_perf) begin
          n_cmp++;
          if (hif.STALL_CYCLES !== e.perf) begin
            n_bad++;
            $display("FAIL %s: STALL_CYCLES got %0d expected %0d", e.name, hif.STALL_CYCLES, e.perf);
          end
        end
      end
    end
  end

  initial begin : stimulus
    hif.ID_RS = '0; hif.ID_RT = '0; hif.ID_USES_RT = 1'b0; hif.EXE_MEMREAD = 1'b0;
    hif.EXE_RD = '0; hif.EXE_BRANCH_TAKEN = 1'b0; hif.DMEM_REQ = 1'b0; hif.DMEM_READY = 1'b0;
    repeat (2) @(posedge CLOCK);

    // Reset held with a would-be load-use and stall on the inputs: everything forced low.
    drive(0, 8, 0, 0, 1, 8, 1, 1, 0, C_RST, "reset_forced", 1, 16'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, "idle_after_reset", 1, 16'd0);

    drive(1, 8, 0, 0, 1, 8, 0, 0, 0, C_LU,   "loaduse_rs", 0, 16'd0);
    idle(C_IDLE, "loaduse_bubble_one_cycle");
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, C_IDLE, "loaduse_rd_zero", 0, 16'd0);

    mem(1, 0, 0, C_MS,   "memwait_1");
    mem(1, 0, 0, C_MS,   "memwait_2");
    mem(1, 0, 0, C_MS,   "memwait_3");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE, "memwait_release", 1, PERF_AFTER_LU_MW);

    mem(1, 1, 0, C_IDLE, "req_ready_same_cycle");
    drive(1, 8, 0, 0, 1, 8, 0, 0, 0, C_LU,   "loaduse_after_ready_hit", 0, 16'd0);

    drive(1, 3, 9, 1, 1, 9, 0, 0, 0, C_LU,   "loaduse_rt_used", 0, 16'd0);
    drive(1, 3, 9, 0, 1, 9, 0, 0, 0, C_IDLE, "loaduse_rt_unused", 0, 16'd0);
    drive(1, 5, 9, 1, 0, 5, 0, 0, 0, C_IDLE, "no_load_match", 0, 16'd0);
    drive(1, 8, 0, 0, 1, 8, 1, 0, 0, C_BR,   "branch_masks_loaduse", 0, 16'd0);

    mem(1, 0, 1, C_MS, "stall_masks_branch_1");
    mem(1, 0, 1, C_MS, "stall_masks_branch_2");
    mem(1, 1, 1, C_BR, "branch_on_release");
    mem(0, 0, 1, C_BR, "branch_plain");

    mem(1, 0, 0, C_MS, "wait_before_reset");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, "reset_mid_wait", 0, 16'd0);
    idle(C_IDLE, "no_residual_stall");

    mem(1, 0, 0, C_MS,  "timeout_1");
    mem(1, 0, 0, C_MS,  "timeout_2");
    mem(1, 0, 0, C_MS,  "timeout_3");
    mem(1, 0, 0, C_MS,  "timeout_4");
    mem(1, 0, 0, C_ERR, "timeout_set_cycle5");
    mem(0, 1, 0, C_ERR, "timeout_sticky_ready");
    mem(0, 0, 1, C_ERR, "timeout_sticky_branch");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST_TMO, "reset_in_error", 0, 16'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, "timeout_cleared", 1, 16'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLOCK);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller for the five-stage MIPS core. It drives the stall and flush controls of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers, plus the PC write enable. It detects load-use hazards and taken-branch redirects, and sequences multicycle data-memory waits through a request/ready handshake. A wait that exceeds a configurable bound is latched as a fatal timeout.

## Interface
Parameters:
- MEM_TIMEOUT_CYCLES, default 255: number of consecutive not-ready memory cycles that triggers ERROR. Legal range is 1..65535.

Ports:
- CLOCK  in  1  single clock; all state updates on posedge.
- RESET  in  1  reset, synchronous and active-low.
- ID_RS  in  5  rs field of the instruction in ID.
- ID_RT  in  5  rt field of the instruction in ID.
- ID_USES_RT  in  1  the ID instruction reads rt.
- EXE_MEMREAD  in  1  the instruction in EXE is a load.
- EXE_RD  in  5  destination register of the EXE instruction.
- EXE_BRANCH_TAKEN  in  1  branch or jump resolved taken in EXE.
- DMEM_REQ  in  1  MEM stage issuing a data-memory access this cycle.
- DMEM_READY  in  1  data memory completes the access this cycle.
- STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB  out  1 each  pipeline register controls.
- PC_WRITE_EN  out  1  PC may update.
- MEM_TIMEOUT  out  1  sticky fatal memory timeout.
- STALL_CYCLES  out  16  performance counter.

## Operation
State machine with three states:
- RUN:
  - Moves to MEM_WAIT when DMEM_REQ=1 and DMEM_READY=0.
  - Otherwise stays in RUN.
- MEM_WAIT:
  - Moves to RUN on DMEM_READY=1.
  - Moves to ERROR when WAIT_CNT reaches MEM_TIMEOUT_CYCLES-1 and DMEM_READY=0.
- ERROR: terminal; only RESET leaves it.

WAIT_CNT:
- Increments on every memory-stall cycle, including the first one, which occurs in RUN.
- Clears when the stall ends.
- Width is sized to hold MEM_TIMEOUT_CYCLES.

Output decode is combinational from the current state and current inputs. Priority is highest first:
1. ERROR: all STALL_* = 1, PC_WRITE_EN=0, MEM_TIMEOUT=1.
2. Memory stall, i.e. (RUN and DMEM_REQ and !DMEM_READY) or (MEM_WAIT and !DMEM_READY):
   - STALL_IFID, STALL_IDEXE and STALL_EXEMEM = 1.
   - FLUSH_MEMWB=1, which sends a bubble to WB.
   - PC_WRITE_EN=0.
3. Redirect (EXE_BRANCH_TAKEN=1): FLUSH_IFID=1, FLUSH_IDEXE=1, PC_WRITE_EN=1.
4. Load-use, i.e. EXE_MEMREAD and EXE_RD≠0 and (EXE_RD==ID_RS or (ID_USES_RT and EXE_RD==ID_RT)): STALL_IFID=1, FLUSH_IDEXE=1, PC_WRITE_EN=0.
5. Otherwise: all STALL_* and FLUSH_* = 0, PC_WRITE_EN=1.

Outputs not listed in a case are 0. FLUSH_EXEMEM is always 0.

Simultaneous events:
- A memory stall masks a pending redirect or load-use. Those are re-evaluated on the release cycle, because EXE is held.
- A redirect masks load-use, because the ID instruction is squashed.
- DMEM_READY=1 in the same cycle as DMEM_REQ means no stall and no state change.

## Timing
- Reset (RESET=0 sampled at posedge):
  - State becomes RUN; WAIT_CNT, MEM_TIMEOUT and STALL_CYCLES become 0.
  - While RESET=0, all STALL_*/FLUSH_* and PC_WRITE_EN are forced to 0.
  - Reset taken mid-MEM_WAIT or in ERROR aborts the wait with no residual stall.
- Stall and flush responses have zero latency: outputs react in the same cycle as the inputs.
- A load-use bubble lasts exactly one cycle.
- A memory stall lasts from the first not-ready cycle through the last not-ready cycle. Outputs return to normal decode in the cycle DMEM_READY=1.
- Timeout: after MEM_TIMEOUT_CYCLES consecutive not-ready cycles, MEM_TIMEOUT=1 from the next cycle onward.

## Configuration
- HAZARD_PERF_EN defined:
  - STALL_CYCLES is a 16-bit register counting cycles with RESET=1 and PC_WRITE_EN=0.
  - It saturates at 0xFFFF and clears on reset.
- HAZARD_PERF_EN undefined: STALL_CYCLES is tied to 0 and no counter logic is built.

## Structure
- Package hazard_pkg holds:
  - the state enum: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10;
  - REG_IDX_W=5;
  - PERF_CNT_W=16.
- One sub-module, hazard_loaduse_detect: combinational load-use compare, including the $0 exclusion.
- The FSM, WAIT_CNT, priority decode and perf counter live in the top module.

## Test plan
- Load-use: EXE_MEMREAD=1, EXE_RD=8, ID_RS=8 → one cycle with STALL_IFID=1, FLUSH_IDEXE=1, PC_WRITE_EN=0. The same case with EXE_RD=0 → no stall.
- Branch with load-use: EXE_BRANCH_TAKEN=1 with a concurrent load-use match → FLUSH_IFID=1, FLUSH_IDEXE=1, PC_WRITE_EN=1, STALL_IFID=0.
- Memory wait: DMEM_REQ=1, DMEM_READY low for 3 cycles then high → 3 cycles of STALL_IFID/STALL_IDEXE/STALL_EXEMEM=1 and FLUSH_MEMWB=1; release in the 4th cycle.
- Timeout: MEM_TIMEOUT_CYCLES=4 with DMEM_READY held low → MEM_TIMEOUT=1 from cycle 5. It stays set after DMEM_READY rises and clears only on RESET=0.
- Stall masking a branch: memory stall concurrent with EXE_BRANCH_TAKEN=1 → no flush during the stall; FLUSH_IFID=1 in the release cycle.
- Perf counter: with HAZARD_PERF_EN defined, one load-use plus a 3-cycle memory wait → STALL_CYCLES=4. Without the macro → STALL_CYCLES=0.
